// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
//   state_t          : fetch FSM states
//   XLEN, CNT_WIDTH  : data/PC width and event-counter width
//   ADDR_WIDTH       : ROM word-address width (ROM aliases above 2^(ADDR_WIDTH+2))
//   PC_STEP          : PC increment per instruction
//   PC_ALIGN_MASK    : forces redirect targets to word alignment
//   DEFAULT_RESET_PC : default first fetch address after reset
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CNT_WIDTH  = 16;
  localparam int unsigned ADDR_WIDTH = 8;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage : fetch_pkg

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch bus: ROM address/data, decode valid/ready handshake and redirect.
//   master : fetch controller side (drives rom_addr and the instruction outputs)
//   slave  : environment side (ROM, decode and branch unit)
interface inst_fetch_ctrl_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] rom_addr;
  logic [XLEN-1:0] rom_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output rom_addr, inst_valid, inst_data, inst_pc,
    input  rom_data, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  rom_addr, inst_valid, inst_data, inst_pc,
    output rom_data, inst_ready, redirect_valid, redirect_pc
  );

endinterface : inst_fetch_ctrl_if

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clock : clock
//   clear : synchronous clear to zero (highest priority)
//   inc   : add one this cycle unless already at all-ones
//   count : current count
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : sat_counter

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle-latency synchronous instruction ROM.
//   clock, reset : clock and synchronous active-high reset
//   run          : fetch enable
//   bus          : ROM address/data, decode valid/ready, redirect (master side)
//   stall_count  : saturating count of cycles with inst_valid & ~inst_ready
//   flush_count  : saturating count of redirects that discarded a live word
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  inst_fetch_ctrl_if.master     bus,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic [CNT_WIDTH-1:0]  flush_count
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] tgt_q;
  logic            valid_q;

  logic [XLEN-1:0] addr_c;
  logic            hold_c;
  logic            issue_c;
  logic            stall_inc_c;
  logic            flush_inc_c;

  // Next state, address selection and issue decision.
  always_comb begin
    state_d = state_q;
    addr_c  = tgt_q;
    hold_c  = 1'b0;
    issue_c = 1'b0;

    case (state_q)
      S_IDLE:  if (run)  state_d = S_RUN;
      S_RUN:   if (!run) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.redirect_valid) begin
      addr_c = bus.redirect_pc & PC_ALIGN_MASK;
    end else if (valid_q && !bus.inst_ready) begin
      // No skid buffer: re-read the held word so rom_data stays stable.
      addr_c = pc_q;
      hold_c = 1'b1;
    end else if (valid_q) begin
      addr_c = pc_q + PC_STEP;
    end

    // state_d is RUN exactly when run=1, so the IDLE->RUN cycle already issues.
    issue_c = (state_d == S_RUN) || hold_c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue_c) begin
        pc_q    <= addr_c;
        valid_q <= 1'b1;
        tgt_q   <= addr_c + PC_STEP;
      end else begin
        valid_q <= 1'b0;
        tgt_q   <= addr_c;
      end
    end
  end

  assign bus.rom_addr   = addr_c;
  assign bus.inst_valid = valid_q & ~bus.redirect_valid;
  assign bus.inst_data  = bus.rom_data;
  assign bus.inst_pc    = pc_q;

  assign stall_inc_c = bus.inst_valid & ~bus.inst_ready;
  assign flush_inc_c = bus.redirect_valid & valid_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clock (clock),
    .clear (reset),
    .inc   (stall_inc_c),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clock (clock),
    .clear (reset),
    .inc   (flush_inc_c),
    .count (flush_count)
  );

endmodule : inst_fetch_ctrl

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: cycle table plus reset and saturation sequences.
module tb_inst_fetch_ctrl;
  import fetch_pkg::*;

  logic        clock;
  logic        reset;
  logic        run;
  logic        run2;
  logic [15:0] stall_count, flush_count;
  logic [15:0] stall_count2, flush_count2;

  int checks;
  int failures;

  inst_fetch_ctrl_if bus ();
  inst_fetch_ctrl_if bus2 ();

  inst_fetch_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .bus         (bus),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  inst_fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut2 (
    .clock       (clock),
    .reset       (reset),
    .run         (run2),
    .bus         (bus2),
    .stall_count (stall_count2),
    .flush_count (flush_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM contents and byte-flipped read data.
  function automatic logic [31:0] mem_word(input logic [ADDR_WIDTH-1:0] idx);
    return {8'hC0, idx, 8'h5A, ~idx};
  endfunction

  function automatic logic [31:0] rom_out(input logic [31:0] addr);
    logic [31:0] w;
    w = mem_word(addr[ADDR_WIDTH+1:2]);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      bus.rom_data  <= '0;
      bus2.rom_data <= '0;
    end else begin
      bus.rom_data  <= rom_out(bus.rom_addr);
      bus2.rom_data <= rom_out(bus2.rom_addr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        run;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_v;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic [15:0] exp_stall;
    logic [15:0] exp_flush;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rd, input logic rv,
                              input logic [31:0] rpc, input logic v,
                              input logic [31:0] pc, input logic [31:0] addr,
                              input logic [15:0] st, input logic [15:0] fl);
    vec_t x;
    x.run = r; x.rdy = rd; x.rv = rv; x.rpc = rpc;
    x.exp_v = v; x.exp_pc = pc; x.exp_addr = addr;
    x.exp_stall = st; x.exp_flush = fl;
    return x;
  endfunction

  localparam int NV = 31;
  vec_t vecs[NV];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;

    // Cycle table: run, rdy, redirect, redirect_pc -> valid, pc, rom_addr, stall, flush
    vecs[0]  = mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0);
    vecs[1]  = mk(1, 1, 0, 32'h0,        1, 32'h0,        32'h4,        0, 0);
    vecs[2]  = mk(1, 1, 0, 32'h0,        1, 32'h4,        32'h8,        0, 0);
    vecs[3]  = mk(1, 1, 0, 32'h0,        1, 32'h8,        32'hC,        0, 0);
    vecs[4]  = mk(1, 1, 0, 32'h0,        1, 32'hC,        32'h10,       0, 0);
    vecs[5]  = mk(1, 1, 1, 32'h8,        0, 32'h0,        32'h8,        0, 0);
    vecs[6]  = mk(1, 0, 0, 32'h0,        1, 32'h8,        32'h8,        0, 1);
    vecs[7]  = mk(1, 0, 0, 32'h0,        1, 32'h8,        32'h8,        1, 1);
    vecs[8]  = mk(1, 0, 0, 32'h0,        1, 32'h8,        32'h8,        2, 1);
    vecs[9]  = mk(1, 1, 0, 32'h0,        1, 32'h8,        32'hC,        3, 1);
    vecs[10] = mk(1, 1, 0, 32'h0,        1, 32'hC,        32'h10,       3, 1);
    vecs[11] = mk(0, 0, 0, 32'h0,        1, 32'h10,       32'h10,       3, 1);
    vecs[12] = mk(0, 0, 0, 32'h0,        1, 32'h10,       32'h10,       4, 1);
    vecs[13] = mk(0, 1, 0, 32'h0,        1, 32'h10,       32'h14,       5, 1);
    vecs[14] = mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h14,       5, 1);
    vecs[15] = mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h14,       5, 1);
    vecs[16] = mk(1, 1, 0, 32'h0,        1, 32'h14,       32'h18,       5, 1);
    vecs[17] = mk(1, 1, 1, 32'h4,        0, 32'h0,        32'h4,        5, 1);
    vecs[18] = mk(1, 1, 1, 32'h43,       0, 32'h0,        32'h40,       5, 2);
    vecs[19] = mk(1, 1, 0, 32'h0,        1, 32'h40,       32'h44,       5, 3);
    vecs[20] = mk(1, 1, 0, 32'h0,        1, 32'h44,       32'h48,       5, 3);
    vecs[21] = mk(0, 1, 1, 32'h80,       0, 32'h0,        32'h80,       5, 3);
    vecs[22] = mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h80,       5, 4);
    vecs[23] = mk(1, 1, 0, 32'h0,        0, 32'h0,        32'h80,       5, 4);
    vecs[24] = mk(1, 1, 0, 32'h0,        1, 32'h80,       32'h84,       5, 4);
    vecs[25] = mk(1, 0, 0, 32'h0,        1, 32'h84,       32'h84,       5, 4);
    vecs[26] = mk(1, 0, 1, 32'h10,       0, 32'h0,        32'h10,       6, 4);
    vecs[27] = mk(1, 1, 0, 32'h0,        1, 32'h10,       32'h14,       6, 5);
    vecs[28] = mk(1, 1, 1, 32'hFFFFFFFF, 0, 32'h0,        32'hFFFFFFFC, 6, 5);
    vecs[29] = mk(1, 1, 0, 32'h0,        1, 32'hFFFFFFFC, 32'h0,        6, 6);
    vecs[30] = mk(1, 1, 0, 32'h0,        1, 32'h0,        32'h4,        6, 6);

    reset = 1'b1;
    run   = 1'b0;
    run2  = 1'b0;
    bus.inst_ready      = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus2.inst_ready     = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;

    // Initial reset state.
    tick();
    tick();
    @(negedge clock);
    check("rst valid",     32'(bus.inst_valid), 32'h0);
    check("rst rom_addr",  bus.rom_addr,        32'h0);
    check("rst stall",     32'(stall_count),    32'h0);
    check("rst flush",     32'(flush_count),    32'h0);
    check("rst2 valid",    32'(bus2.inst_valid), 32'h0);
    check("rst2 rom_addr", bus2.rom_addr,       32'h100);
    tick();
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run                = vecs[i].run;
      bus.inst_ready     = vecs[i].rdy;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc    = vecs[i].rpc;
      @(negedge clock);
      check($sformatf("r%0d valid", i), 32'(bus.inst_valid), 32'(vecs[i].exp_v));
      check($sformatf("r%0d rom_addr", i), bus.rom_addr, vecs[i].exp_addr);
      check($sformatf("r%0d stall", i), 32'(stall_count), 32'(vecs[i].exp_stall));
      check($sformatf("r%0d flush", i), 32'(flush_count), 32'(vecs[i].exp_flush));
      if (vecs[i].exp_v) begin
        check($sformatf("r%0d pc", i), bus.inst_pc, vecs[i].exp_pc);
        check($sformatf("r%0d data", i), bus.inst_data, rom_out(vecs[i].exp_pc));
      end
      tick();
    end
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset mid-stream with a stalled word pending.
    run = 1'b1;
    bus.inst_ready = 1'b0;
    @(negedge clock);
    check("pre-rst valid", 32'(bus.inst_valid), 32'h1);
    check("pre-rst pc",    bus.inst_pc,         32'h4);
    tick();
    reset = 1'b1;
    bus.inst_ready = 1'b1;
    tick();
    @(negedge clock);
    check("mid-rst valid",    32'(bus.inst_valid), 32'h0);
    check("mid-rst rom_addr", bus.rom_addr,        32'h0);
    check("mid-rst stall",    32'(stall_count),    32'h0);
    check("mid-rst flush",    32'(flush_count),    32'h0);
    check("mid-rst rom_data", bus.rom_data,        32'h0);
    check("mid-rst2 addr",    bus2.rom_addr,       32'h100);
    tick();
    reset = 1'b0;
    run2  = 1'b1;
    @(negedge clock);
    check("restart valid",     32'(bus.inst_valid),  32'h0);
    check("restart rom_addr",  bus.rom_addr,         32'h0);
    check("restart2 valid",    32'(bus2.inst_valid), 32'h0);
    check("restart2 rom_addr", bus2.rom_addr,        32'h100);
    tick();
    @(negedge clock);
    check("restart+1 valid", 32'(bus.inst_valid),  32'h1);
    check("restart+1 pc",    bus.inst_pc,          32'h0);
    check("restart+1 data",  bus.inst_data,        rom_out(32'h0));
    check("restart2+1 valid", 32'(bus2.inst_valid), 32'h1);
    check("restart2+1 pc",   bus2.inst_pc,         32'h100);
    check("restart2+1 data", bus2.inst_data,       rom_out(32'h100));
    check("restart2+1 addr", bus2.rom_addr,        32'h104);
    tick();
    @(negedge clock);
    check("restart+2 pc",  bus.inst_pc,  32'h4);
    check("restart2+2 pc", bus2.inst_pc, 32'h104);
    tick();

    // Stall counter saturation: word at pc 8 held far beyond 2^16 cycles.
    bus.inst_ready = 1'b0;
    repeat (70000) tick();
    @(negedge clock);
    check("sat stall",    32'(stall_count),    32'hFFFF);
    check("sat valid",    32'(bus.inst_valid), 32'h1);
    check("sat pc",       bus.inst_pc,         32'h8);
    check("sat rom_addr", bus.rom_addr,        32'h8);
    check("sat flush",    32'(flush_count),    32'h0);
    tick();
    @(negedge clock);
    check("sat stall hold", 32'(stall_count), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_inst_fetch_ctrl
